reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the 8x16 single-write register block.
- Adds a second write port for late load returns, optional write-through bypass, an optional hardwired-zero register, and a pending-load scoreboard.
- The scoreboard raises a stall when a read operand is still waiting on an outstanding load.
- Sits between decode (read/issue) and writeback (ALU and load return) in the CPU datapath.

Parameters:
- n, 16: data width in bits.
- reg_count, 8: number of registers; must equal 2**addr_size.
- addr_size, 3: register address width.
- ZERO_REG, 0: 1 = register 0 always reads 0, writes to it are discarded, and it can never be marked pending.
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports.

Ports:
- Clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous reset, active low.
- Rs1  input  addr_size  read address, port 1.
- Rs2  input  addr_size  read address, port 2.
- Rd1  output  n  read data, port 1.
- Rd2  output  n  read data, port 2.
- WeA  input  1  write enable, ALU writeback port A.
- RwA  input  addr_size  write address, port A.
- WDataA  input  n  write data, port A.
- WeB  input  1  write enable, load-return port B.
- RwB  input  addr_size  write address, port B.
- WDataB  input  n  write data, port B.
- LdIssue  input  1  a load targeting LdRw issues this cycle.
- LdRw  input  addr_size  destination register of the issuing load.
- Stall  output  1  an operand on Rs1 or Rs2 is pending.
- PendCount  output  addr_size+1  number of set pending bits.
- Overlap  output  1  sticky error flag.

Behaviour:
- Reset: clock and reset are already decided as one clock, Clock, and nReset, asynchronous active-low. While nReset=0, all registers=0, pending[]=0, PendCount=0, Overlap=0. Consequently Rd1/Rd2=0 and Stall=0, subject to the same-cycle bypass below.
- Reads: combinational. Rd1 = regs[Rs1], Rd2 = regs[Rs2]. If ZERO_REG=1 and the address is 0, the read returns 0.
- Writes: registered on the rising Clock edge.
  - WeA writes WDataA to regs[RwA].
  - WeB writes WDataB to regs[RwB].
  - Both ports to the same address in the same cycle: port A data is stored and port B data is dropped.
- Bypass (BYPASS=1), applied per read port:
  - If WeA and RwA matches the read address, return WDataA.
  - Else if WeB and RwB matches, return WDataB.
  - Else return the stored value.
  - ZERO_REG masking is applied after bypass.
  - With BYPASS=0 the new value is visible the cycle after the write.
- Scoreboard, next-state of pending[r], evaluated per register:
  - Set if LdIssue and LdRw==r. This takes priority over a clear in the same cycle, because it is a new load.
  - Else clear if WeB and RwB==r.
  - Else hold.
  - Port A writes never change pending bits.
  - With ZERO_REG=1, LdIssue to register 0 is ignored.
- Stall = p1 | p2, where px = pending[Rsx], excluding register 0 when ZERO_REG=1.
  - With BYPASS=1, px is additionally masked when WeB with RwB==Rsx occurs this cycle, because the load data is forwarded.
- PendCount: registered; equals popcount of pending[] after each edge. It is a count, so it is never wrapped.
- Overlap: set on the edge where LdIssue targets a register whose pending bit is already set and is not being cleared by WeB that same cycle. Once set it is held until reset.
- Reset mid-operation: all pending bits drop immediately and asynchronously; outstanding load returns after reset write normally and do not set bits.

Test Plan:
1. Reset then WeA=1, RwA=3, WDataA=16'hBEEF -> the next cycle, Rs1=3 gives Rd1=16'hBEEF. With BYPASS=1, Rd1=16'hBEEF already in the write cycle.
2. LdIssue, LdRw=5 -> PendCount=1. Then Rs2=5 gives Stall=1. WeB=1, RwB=5, WDataB=16'h1234 -> Stall=0 and Rd2=16'h1234 that cycle (BYPASS=1); PendCount=0 after the edge.
3. Same-cycle WeA and WeB to register 2 with data 16'h00AA and 16'h00BB -> reg2=16'h00AA; the pending bit is cleared if it was set.
4. LdIssue to register 4 twice without a return -> Overlap=1 and stays 1. LdIssue and WeB to register 4 in the same cycle -> pending stays set and Overlap is unchanged.
5. ZERO_REG=1: WeA to register 0 with 16'hFFFF -> Rd1=0 for Rs1=0. LdIssue to register 0 -> PendCount unchanged and Stall=0.
6. Issue loads to registers 1, 2, 6 (PendCount=3), then pulse nReset low mid-cycle -> all outputs are 0 immediately, with no waiting for the clock.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with dual write ports (ALU + load return), optional
// write-through bypass, optional hardwired zero register and a pending-load scoreboard.
module reg_file_sb #(
    parameter int unsigned n         = 16,
    parameter int unsigned reg_count = 8,
    parameter int unsigned addr_size = 3,
    parameter bit          ZERO_REG  = 1'b0,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [addr_size-1:0] Rs1,
    input  logic [addr_size-1:0] Rs2,
    output logic [n-1:0]         Rd1,
    output logic [n-1:0]         Rd2,
    input  logic                 WeA,
    input  logic [addr_size-1:0] RwA,
    input  logic [n-1:0]         WDataA,
    input  logic                 WeB,
    input  logic [addr_size-1:0] RwB,
    input  logic [n-1:0]         WDataB,
    input  logic                 LdIssue,
    input  logic [addr_size-1:0] LdRw,
    output logic                 Stall,
    output logic [addr_size:0]   PendCount,
    output logic                 Overlap
);

    localparam int unsigned cnt_w = addr_size + 1;

    logic [n-1:0]         regs [reg_count];
    logic [reg_count-1:0] pending;
    logic [reg_count-1:0] pending_nxt;
    logic [cnt_w-1:0]     pend_cnt_nxt;
    logic                 overlap_set;

    function automatic logic is_zero(input logic [addr_size-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    function automatic logic [n-1:0] read_port(input logic [addr_size-1:0] rs);
        logic [n-1:0] d;
        d = regs[rs];
        if (BYPASS && WeA && (RwA == rs)) begin
            d = WDataA;
        end else if (BYPASS && WeB && (RwB == rs)) begin
            d = WDataB;
        end
        if (is_zero(rs)) begin
            d = '0;
        end
        return d;
    endfunction

    // A returning load whose data is being forwarded no longer blocks its reader
    function automatic logic pend_hit(input logic [addr_size-1:0] rs);
        return pending[rs] && !is_zero(rs) && !(BYPASS && WeB && (RwB == rs));
    endfunction

    // Storage: port A wins when both ports target the same register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (WeB && !is_zero(RwB) && !(WeA && (RwA == RwB))) begin
                regs[RwB] <= WDataB;
            end
            if (WeA && !is_zero(RwA)) begin
                regs[RwA] <= WDataA;
            end
        end
    end

    always_comb begin
        Rd1   = read_port(Rs1);
        Rd2   = read_port(Rs2);
        Stall = pend_hit(Rs1) | pend_hit(Rs2);
    end

    // Scoreboard next state: a new load issue overrides a same-cycle return
    always_comb begin
        pending_nxt  = pending;
        pend_cnt_nxt = '0;
        for (int unsigned i = 0; i < reg_count; i++) begin
            if (LdIssue && (LdRw == addr_size'(i)) && !is_zero(addr_size'(i))) begin
                pending_nxt[i] = 1'b1;
            end else if (WeB && (RwB == addr_size'(i))) begin
                pending_nxt[i] = 1'b0;
            end
            pend_cnt_nxt = pend_cnt_nxt + cnt_w'(pending_nxt[i]);
        end
    end

    always_comb begin
        overlap_set = LdIssue && pending[LdRw] && !(WeB && (RwB == LdRw));
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pending   <= '0;
            PendCount <= '0;
            Overlap   <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            PendCount <= pend_cnt_nxt;
            Overlap   <= Overlap | overlap_set;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default instance (bypass, no zero reg) and a
// ZERO_REG=1 / BYPASS=0 instance driven by the same stimulus.
module tb_reg_file_sb;

    localparam int unsigned n  = 16;
    localparam int unsigned aw = 3;

    logic          clk;
    logic          rst_n;
    logic [aw-1:0] rs1, rs2, rwa, rwb, ldrw;
    logic [n-1:0]  wdata_a, wdata_b;
    logic          we_a, we_b, ld_issue;

    logic [n-1:0]  rd1, rd2, zrd1, zrd2;
    logic          stall, zstall, overlap, zoverlap;
    logic [aw:0]   pend, zpend;

    int tests_run;
    int tests_failed;

    reg_file_sb u_dut (
        .Clock(clk), .nReset(rst_n), .Rs1(rs1), .Rs2(rs2), .Rd1(rd1), .Rd2(rd2),
        .WeA(we_a), .RwA(rwa), .WDataA(wdata_a), .WeB(we_b), .RwB(rwb), .WDataB(wdata_b),
        .LdIssue(ld_issue), .LdRw(ldrw), .Stall(stall), .PendCount(pend), .Overlap(overlap)
    );

    reg_file_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_z (
        .Clock(clk), .nReset(rst_n), .Rs1(rs1), .Rs2(rs2), .Rd1(zrd1), .Rd2(zrd2),
        .WeA(we_a), .RwA(rwa), .WDataA(wdata_a), .WeB(we_b), .RwB(rwb), .WDataB(wdata_b),
        .LdIssue(ld_issue), .LdRw(ldrw), .Stall(zstall), .PendCount(zpend), .Overlap(zoverlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; ld_issue = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; idle();
        rs1 = '0; rs2 = '0; rwa = '0; rwb = '0; ldrw = '0; wdata_a = '0; wdata_b = '0;

        // reset state
        #3;
        check("rst_rd1", 32'(rd1), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_overlap", 32'(overlap), 32'h0);
        #9 rst_n = 1'b1;
        step();

        // 1: ALU write with and without bypass
        we_a = 1'b1; rwa = 3'd3; wdata_a = 16'hBEEF; rs1 = 3'd3;
        #1;
        check("t1_bypass_rd1", 32'(rd1), 32'hBEEF);
        check("t1_nobyp_rd1", 32'(zrd1), 32'h0);
        step(); idle(); #1;
        check("t1_stored_rd1", 32'(rd1), 32'hBEEF);
        check("t1_z_stored_rd1", 32'(zrd1), 32'hBEEF);

        // 2: load issue, stall, forwarded return
        ld_issue = 1'b1; ldrw = 3'd5;
        step(); idle();
        check("t2_pend", 32'(pend), 32'd1);
        rs2 = 3'd5; #1;
        check("t2_stall", 32'(stall), 32'd1);
        check("t2_z_stall", 32'(zstall), 32'd1);
        we_b = 1'b1; rwb = 3'd5; wdata_b = 16'h1234; #1;
        check("t2_ret_stall", 32'(stall), 32'd0);
        check("t2_ret_rd2", 32'(rd2), 32'h1234);
        check("t2_z_ret_stall", 32'(zstall), 32'd1);
        check("t2_z_ret_rd2", 32'(zrd2), 32'h0);
        step(); idle(); #1;
        check("t2_pend_after", 32'(pend), 32'd0);
        check("t2_stall_after", 32'(stall), 32'd0);
        check("t2_z_rd2_after", 32'(zrd2), 32'h1234);

        // 3: same-cycle A/B write collision on a pending register
        ld_issue = 1'b1; ldrw = 3'd2;
        step(); idle();
        check("t3_pend_set", 32'(pend), 32'd1);
        we_a = 1'b1; rwa = 3'd2; wdata_a = 16'h00AA;
        we_b = 1'b1; rwb = 3'd2; wdata_b = 16'h00BB; rs1 = 3'd2; #1;
        check("t3_bypass_prio", 32'(rd1), 32'h00AA);
        step(); idle(); #1;
        check("t3_rd1", 32'(rd1), 32'h00AA);
        check("t3_z_rd1", 32'(zrd1), 32'h00AA);
        check("t3_pend_clr", 32'(pend), 32'd0);

        // 4: reissue with same-cycle return is not an overlap; reissue without is
        ld_issue = 1'b1; ldrw = 3'd4;
        step();
        we_b = 1'b1; rwb = 3'd4; wdata_b = 16'h4444;
        step(); idle();
        check("t4_pend_kept", 32'(pend), 32'd1);
        check("t4_no_overlap", 32'(overlap), 32'd0);
        ld_issue = 1'b1; ldrw = 3'd4;
        step(); idle();
        check("t4_overlap", 32'(overlap), 32'd1);
        check("t4_z_overlap", 32'(zoverlap), 32'd1);
        step();
        check("t4_overlap_sticky", 32'(overlap), 32'd1);
        we_b = 1'b1; rwb = 3'd4; wdata_b = 16'h4444;
        step(); idle();
        check("t4_pend_clr", 32'(pend), 32'd0);

        // 5: hardwired zero register
        we_a = 1'b1; rwa = 3'd0; wdata_a = 16'hFFFF;
        step(); idle();
        rs1 = 3'd0; #1;
        check("t5_z_rd1_zero", 32'(zrd1), 32'h0);
        check("t5_rd1_r0", 32'(rd1), 32'hFFFF);
        ld_issue = 1'b1; ldrw = 3'd0;
        step(); idle();
        check("t5_z_pend", 32'(zpend), 32'd0);
        check("t5_pend", 32'(pend), 32'd1);
        check("t5_z_stall", 32'(zstall), 32'd0);
        check("t5_stall", 32'(stall), 32'd1);
        we_b = 1'b1; rwb = 3'd0; wdata_b = 16'h0;
        step(); idle();
        check("t5_pend_clr", 32'(pend), 32'd0);

        // 6: fill every pending bit (count must not wrap), then async reset
        for (int i = 0; i < 8; i++) begin
            ld_issue = 1'b1; ldrw = 3'(i);
            step();
        end
        idle();
        check("t6_pend_full", 32'(pend), 32'd8);
        check("t6_z_pend_full", 32'(zpend), 32'd7);
        rs1 = 3'd1; rs2 = 3'd6; #1;
        check("t6_stall", 32'(stall), 32'd1);
        rst_n = 1'b0; #1;
        check("t6_rst_pend", 32'(pend), 32'd0);
        check("t6_rst_stall", 32'(stall), 32'd0);
        check("t6_rst_overlap", 32'(overlap), 32'd0);
        check("t6_rst_rd2", 32'(rd2), 32'h0);
        check("t6_z_rst_pend", 32'(zpend), 32'd0);
        rst_n = 1'b1;

        // late load return after reset writes normally, sets no bit
        we_b = 1'b1; rwb = 3'd1; wdata_b = 16'h5555;
        step(); idle(); #1;
        check("t6_late_rd1", 32'(rd1), 32'h5555);
        check("t6_late_pend", 32'(pend), 32'd0);
        check("t6_late_stall", 32'(stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
